// File: rtl/me_iddmm_seq.sv
// Sequencer that owns one modular-exponentiation job in front of me_iddmm_top: operand buffer,
// start/gap/stream control and result collection. Optional watchdog: define ME_SEQ_WATCHDOG_EN.
module me_iddmm_seq #(
    parameter int unsigned K   = 128,
    parameter int unsigned N   = 16,
    parameter int unsigned GAP = 10,
    parameter int unsigned AW  = 4,
    parameter int unsigned TMO = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [K-1:0]  wr_data,
    input  logic          cmd_start,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [K-1:0]  rd_data,
    output logic          me_start,
    output logic [K-1:0]  me_x,
    output logic          me_x_valid,
    input  logic [K-1:0]  me_result,
    input  logic          me_valid,
    output logic          err
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    if (GAP < 1 || TMO < 2 || (1 << AW) < N) begin : g_bad_cfg
        $error("me_iddmm_seq: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StStart, StGap, StSend, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [AW-1:0]   send_q, send_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic [K-1:0]    me_x_q, me_x_d;
    logic            me_x_valid_q, me_x_valid_d;
    logic [K-1:0]    op_buf  [N];
    logic [K-1:0]    res_buf [N];
    logic            op_we, res_acc, res_last;
    logic [AW-1:0]   res_idx;

    // Results are accepted in SEND as well as WAIT, but never beyond N words per job.
    assign op_we    = (state_q == StIdle) && wr_en && (32'(wr_addr) < N);
    assign res_acc  = me_valid && (state_q inside {StSend, StWait}) && (res_cnt_q < CW'(N));
    assign res_last = res_acc && (res_cnt_q == CW'(N - 1));
    // Engine returns MSW first, so the k-th result lands at index N-1-k.
    assign res_idx  = AW'(N - 1) - res_cnt_q[AW-1:0];

`ifdef ME_SEQ_WATCHDOG_EN
    localparam int unsigned WW = $clog2(TMO + 1);
    logic [WW-1:0] wdt_q, wdt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        send_d       = send_q;
        res_cnt_d    = res_cnt_q;
        me_x_valid_d = 1'b0;
        me_x_d       = '0;
`ifdef ME_SEQ_WATCHDOG_EN
        err_d        = err_q;
        wdt_d        = '0;
        if (state_q == StWait) begin
            wdt_d = res_acc ? WW'(1) : wdt_q + WW'(1);
        end else if (state_q == StSend && res_acc) begin
            wdt_d = WW'(1);
        end
`endif
        if (res_acc) begin
            res_cnt_d = res_cnt_q + CW'(1);
        end
        case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d   = StStart;
                    res_cnt_d = '0;
`ifdef ME_SEQ_WATCHDOG_EN
                    err_d     = 1'b0;
`endif
                end
            end
            StStart: begin
                state_d = StGap;
                gap_d   = '0;
            end
            StGap: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = StSend;
                    send_d  = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StSend: begin
                if (send_q == AW'(N - 1)) begin
                    state_d = StWait;
                end else begin
                    send_d = send_q + AW'(1);
                end
            end
            StWait: begin
                if (res_last || res_cnt_q == CW'(N)) begin
                    state_d = StDone;
`ifdef ME_SEQ_WATCHDOG_EN
                end else if (wdt_q == WW'(TMO - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Operand stream is registered: load the word for the next SEND cycle.
        if (state_d == StSend) begin
            me_x_valid_d = 1'b1;
            me_x_d       = op_buf[send_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            send_q       <= '0;
            res_cnt_q    <= '0;
            me_x_q       <= '0;
            me_x_valid_q <= 1'b0;
`ifdef ME_SEQ_WATCHDOG_EN
            wdt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            send_q       <= send_d;
            res_cnt_q    <= res_cnt_d;
            me_x_q       <= me_x_d;
            me_x_valid_q <= me_x_valid_d;
`ifdef ME_SEQ_WATCHDOG_EN
            wdt_q        <= wdt_d;
            err_q        <= err_d;
`endif
        end
    end

    // Buffers are never cleared; a reset mid-job leaves partial results in place.
    always_ff @(posedge clk) begin
        if (op_we) begin
            op_buf[wr_addr] <= wr_data;
        end
        if (rst_n && res_acc) begin
            res_buf[res_idx] <= me_result;
        end
    end

    assign rd_data    = (32'(rd_addr) < N) ? res_buf[rd_addr] : '0;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign me_start   = (state_q == StStart);
    assign me_x       = me_x_q;
    assign me_x_valid = me_x_valid_q;
`ifdef ME_SEQ_WATCHDOG_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_me_iddmm_seq.sv
// Directed bench for me_iddmm_seq: stream timing, result ordering, locking, reset mid-job and
// (with ME_SEQ_WATCHDOG_EN) the watchdog timeout.
module tb_me_iddmm_seq;

    localparam int unsigned K   = 128;
    localparam int unsigned N   = 16;
    localparam int unsigned GAP = 10;
    localparam int unsigned AW  = 4;
`ifdef ME_SEQ_WATCHDOG_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 65535;
`endif

    logic          clk = 1'b0;
    logic          rst_n, wr_en, cmd_start, me_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [K-1:0]  wr_data, me_result;
    logic          busy, done, me_start, me_x_valid, err;
    logic [K-1:0]  rd_data, me_x;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [K-1:0]  exp;
    } rd_vec_t;

    me_iddmm_seq #(.K(K), .N(N), .GAP(GAP), .AW(AW), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_start  (cmd_start),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .me_start   (me_start),
        .me_x       (me_x),
        .me_x_valid (me_x_valid),
        .me_result  (me_result),
        .me_valid   (me_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [K-1:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic start_job();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("me_start_high", K'(me_start), K'(1));
        chk("busy_rise", K'(busy), K'(1));
    endtask

    // Checks gap latency and the N-word stream carrying 1..N; optionally pokes cmd_start/wr_en.
    task automatic stream(input bit tamper);
        int cnt;
        tick();
        cnt = 1;
        chk("me_start_pulse", K'(me_start), K'(0));
        while (!me_x_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("gap_latency", K'(cnt), K'(GAP + 1));
        for (int i = 0; i < N; i++) begin
            chk("x_valid", K'(me_x_valid), K'(1));
            chk("x_word", me_x, K'(i + 1));
            if (tamper && i == 5) begin
                cmd_start = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = '0;
                wr_data   = K'('hDEAD);
            end
            tick();
            cmd_start = 1'b0;
            wr_en     = 1'b0;
        end
        chk("x_valid_end", K'(me_x_valid), K'(0));
        chk("x_word_end", me_x, '0);
        chk("busy_wait", K'(busy), K'(1));
    endtask

    // Engine model: k-th word is base + (N-1-k), so result index i should read base + i.
    task automatic feed(input int n, input logic [K-1:0] base);
        for (int k = 0; k < n; k++) begin
            me_valid  = 1'b1;
            me_result = base + K'(N - 1 - k);
            if (k == n - 1 && n == N) begin
                #1;
            end else begin
                chk("no_early_done", K'(done), K'(0));
            end
            tick();
        end
        me_valid  = 1'b0;
        me_result = '0;
    endtask

    task automatic finish_job();
        chk("done_pulse", K'(done), K'(1));
        chk("busy_in_done", K'(busy), K'(1));
        tick();
        chk("done_fall", K'(done), K'(0));
        chk("busy_fall", K'(busy), K'(0));
    endtask

    initial begin
        rd_vec_t job1_tbl[6];
        job1_tbl[0] = '{addr: 4'd0,  exp: K'('h0)};
        job1_tbl[1] = '{addr: 4'd15, exp: K'('hF)};
        job1_tbl[2] = '{addr: 4'd1,  exp: K'('h1)};
        job1_tbl[3] = '{addr: 4'd7,  exp: K'('h7)};
        job1_tbl[4] = '{addr: 4'd8,  exp: K'('h8)};
        job1_tbl[5] = '{addr: 4'd14, exp: K'('hE)};

        rst_n = 1'b0; wr_en = 1'b0; cmd_start = 1'b1; me_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; me_result = '0;
        repeat (3) tick();
        chk("rst_busy", K'(busy), K'(0));
        chk("rst_me_start", K'(me_start), K'(0));
        chk("rst_x_valid", K'(me_x_valid), K'(0));
        chk("rst_me_x", me_x, '0);
        chk("rst_done", K'(done), K'(0));
        chk("rst_err", K'(err), K'(0));
        rst_n = 1'b1;
        cmd_start = 1'b0;
        tick();
        chk("idle_busy", K'(busy), K'(0));

        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = K'(i + 1);
            tick();
        end
        wr_en = 1'b0;

        // Job 1: nominal run
        start_job();
        stream(1'b0);
        feed(N, '0);
        finish_job();
        foreach (job1_tbl[i]) rd_chk("rd_job1", job1_tbl[i].addr, job1_tbl[i].exp);

        // me_valid in IDLE must not be stored
        me_valid = 1'b1; me_result = K'('hBAD);
        tick();
        me_valid = 1'b0;
        rd_chk("idle_valid_ignored15", 4'd15, K'('hF));
        rd_chk("idle_valid_ignored0", 4'd0, K'('h0));

        // Job 2: cmd_start and write poked mid-SEND
        start_job();
        stream(1'b1);
        feed(N, K'('h100));
        finish_job();
        rd_chk("rd_job2_10", 4'd10, K'('h10A));

        // Job 3: stream shows word 0 unchanged; reset after 5 results
        start_job();
        stream(1'b0);
        feed(5, K'('h200));
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", K'(busy), K'(0));
        chk("midrst_x_valid", K'(me_x_valid), K'(0));
        chk("midrst_done", K'(done), K'(0));
        rst_n = 1'b1;
        tick();
        rd_chk("partial_15", 4'd15, K'('h20F));
        rd_chk("partial_11", 4'd11, K'('h20B));
        rd_chk("partial_10", 4'd10, K'('h10A));

        // Job 4: no stale count; extra me_valid in DONE ignored
        start_job();
        stream(1'b0);
        feed(N, K'('h300));
        me_valid = 1'b1; me_result = K'('hBEEF);
        finish_job();
        me_valid = 1'b0;
        for (int i = 0; i < N; i++) rd_chk("rd_job4", AW'(i), K'('h300 + i));

`ifdef ME_SEQ_WATCHDOG_EN
        begin
            int n;
            bit done_seen;
            start_job();
            stream(1'b0);
            feed(8, K'('h400));
            n = 1;
            done_seen = 1'b0;
            while (!err && n < 300) begin
                tick();
                n++;
                if (done) done_seen = 1'b1;
            end
            chk("wdt_latency", K'(n), K'(TMO));
            chk("wdt_no_done", K'(done_seen), K'(0));
            chk("wdt_idle", K'(busy), K'(0));
            tick();
            chk("wdt_err_sticky", K'(err), K'(1));
            start_job();
            chk("wdt_err_clear", K'(err), K'(0));
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
